logic_op_pipe: RTL and testbench
================================

LOGIC_OP_PIPE -- requirements
Module: logic_op_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand/result width in bits, legal range 1..32.
REQ-002 SHALL have parameter CNTW, default 8: beat-counter width in bits, legal range 2..16.
REQ-003 SHALL have one clock and an asynchronous active-low reset, named as follows.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port inValid, input, 1 bit: input beat present.
REQ-007 SHALL have port inReady, output, 1 bit: block can accept a beat.
REQ-008 SHALL have port aIn, input, WIDTH bits: operand A.
REQ-009 SHALL have port bIn, input, WIDTH bits: operand B.
REQ-010 SHALL have port opSel, input, 2 bits: 0 AND, 1 OR, 2 XOR, 3 NOR.
REQ-011 SHALL have port accMode, input, 1 bit: 1 folds a burst into one result.
REQ-012 SHALL have port inLast, input, 1 bit: final beat of a burst; ignored when accMode=0.
REQ-013 SHALL have port outValid, output, 1 bit: result present.
REQ-014 SHALL have port outReady, input, 1 bit: consumer accepts the result.
REQ-015 SHALL have port out, output, WIDTH bits: result.
REQ-016 SHALL have port opOut, output, 2 bits: opSel used for this result.
REQ-017 SHALL have port beatCnt, output, CNTW bits: beats folded into this result.

Function
REQ-018 SHALL accept an input beat only in a cycle where inValid=1 and inReady=1, and a result only where outValid=1 and outReady=1.
REQ-019 SHALL compute per beat r = aIn op bIn, bitwise, with op selected by opSel.
REQ-020 SHALL, when accMode=0 (state IDLE), queue each accepted beat as a result {r, opSel, beatCnt=1}; outValid rises the cycle after acceptance when the queue was empty (latency 1).
REQ-021 SHALL, on acceptance with accMode=1 and inLast=0 in IDLE, load acc=r, latch opSel and accMode, set count to 1, and move to ACCUM.
REQ-022 SHALL, on each accepted beat in ACCUM, set acc = acc op_latched r; opSel and accMode inputs are ignored until the burst ends.
REQ-023 SHALL, when the accepted beat has inLast=1, queue {acc op r, latched op, count+1} and return to IDLE; a first beat with accMode=1 and inLast=1 is queued as a single-beat result.
REQ-024 SHALL saturate the beat count at 2^CNTW-1, without wrapping to 0.
REQ-025 SHALL use a 2-entry output FIFO; inReady = (entries < 2), driven from registers only (no combinational path from outReady).
REQ-026 SHALL keep throughput at one beat per cycle when outReady is held 1; enqueue and dequeue in the same cycle at 2 entries is not allowed (inReady=0), and at 1 entry leaves the count unchanged.
REQ-027 SHALL hold out, opOut and beatCnt stable while outValid=1 and outReady=0.
REQ-028 SHALL make beats in ACCUM that do not complete the burst consume no FIFO entry; inReady still follows REQ-025.

Reset
REQ-029 SHALL, when rst_n=0, immediately set state to IDLE, FIFO empty, acc=0, count=0, and outputs outValid=0, inReady=0, out=0, opOut=0, beatCnt=0.
REQ-030 SHALL drive inReady=1 in the first cycle after rst_n deasserts.
REQ-031 SHALL discard any partial burst and queued results when reset is asserted mid-operation; nothing is emitted for them.

Structure
REQ-032 SHALL place the opSel encodings, the state encoding (IDLE, ACCUM) and the FIFO depth constant in shared package logic_op_pkg.
REQ-033 SHALL implement the 2-entry output queue as sub-module logic_op_fifo2, parametrised by data width (WIDTH+2+CNTW).

Verification
REQ-034 SHALL check: WIDTH=4, accMode=0, outReady=1, beats (1100,1010) under ops 0..3 -> results 1000, 1110, 0110, 0001 on consecutive cycles, each 1 cycle after its input, beatCnt=1.
REQ-035 SHALL check: accMode=1, XOR, beats 0001/0000, 0010/0000, 0100/0000 with inLast on the third -> one result 0111, opOut=2, beatCnt=3.
REQ-036 SHALL check: outReady=0 and 3 beats offered -> 2 accepted, inReady=0 on the third; outReady=1 -> drains in order, and out stays stable while stalled.
REQ-037 SHALL check: CNTW=2, AND burst of 5 beats of 1111/1111 -> out=1111, beatCnt=3 (saturated).
REQ-038 SHALL check: rst_n pulsed low mid-burst after 2 beats -> outValid=0 at once; a new accMode=0 beat 0011/0101 OR -> 0111, beatCnt=1.
REQ-039 SHALL check: opSel changed mid-burst from OR to AND -> result uses OR and opOut=1.

Source files
------------

// File: rtl/logic_op_pkg.sv
// logic_op_pkg: shared definitions for the logic_op_pipe block.
//   op_e      - opSel encodings (AND, OR, XOR, NOR)
//   state_e   - fold FSM states (IDLE, ACCUM)
//   FifoDepth - number of result entries the output queue holds
//   apply_op  - bitwise operator evaluated on up to 32-bit operands
package logic_op_pkg;

  typedef enum logic [1:0] {
    OpAnd = 2'd0,
    OpOr  = 2'd1,
    OpXor = 2'd2,
    OpNor = 2'd3
  } op_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } state_e;

  localparam int unsigned FifoDepth = 2;

  // Callers zero-extend narrower operands and truncate the result; NOR sets the
  // unused upper bits, which the truncation discards.
  function automatic logic [31:0] apply_op(input logic [1:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    res = '0;
    unique case (op_e'(op))
      OpAnd: res = a & b;
      OpOr:  res = a | b;
      OpXor: res = a ^ b;
      OpNor: res = ~(a | b);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_op_fifo2.sv
// logic_op_fifo2: two-entry result queue with a registered head.
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - enqueue push_data (ignored when full)
//   push_data   - entry to enqueue
//   pop         - dequeue the head (ignored when empty)
//   ready       - queue has a free entry (from the occupancy register)
//   valid       - head holds an entry
//   head        - oldest entry; slot 0 register, stable until popped
module logic_op_fifo2
  import logic_op_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          ready,
  output logic          valid,
  output logic [DW-1:0] head
);

  localparam logic [1:0] Depth = 2'(FifoDepth);

  logic [1:0]    count_q, count_d;
  logic [DW-1:0] slot0_q, slot0_d;
  logic [DW-1:0] slot1_q, slot1_d;
  logic          push_ok, pop_ok;

  always_comb begin
    push_ok = push && (count_q != Depth);
    pop_ok  = pop && (count_q != 2'd0);
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data;
        else                 slot1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      // Push with pop is only possible at one entry: the new entry becomes head.
      2'b11: slot0_d = push_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign ready = (count_q != Depth);
  assign valid = (count_q != 2'd0);
  assign head  = slot0_q;

endmodule

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: bitwise logic operator with optional burst folding and a
// two-entry output queue.
//   clk, rst_n          - clock, asynchronous active-low reset
//   inValid, inReady    - input beat handshake
//   aIn, bIn            - operands
//   opSel               - 0 AND, 1 OR, 2 XOR, 3 NOR
//   accMode, inLast     - fold a burst into one result; inLast ends the burst
//   outValid, outReady  - result handshake
//   out, opOut, beatCnt - result, operator used, beats folded (saturating)
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  input  logic [1:0]       opSel,
  input  logic             accMode,
  input  logic             inLast,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       opOut,
  output logic [CNTW-1:0]  beatCnt
);

  localparam int unsigned   DW     = WIDTH + 2 + CNTW;
  localparam logic [CNTW-1:0] CntOne = CNTW'(1);
  localparam logic [CNTW-1:0] CntMax = '1;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [1:0]       op_q;
  logic [CNTW-1:0]  cnt_q;

  logic [1:0]       beat_op;
  logic [WIDTH-1:0] beat_res;
  logic [WIDTH-1:0] fold_res;
  logic [CNTW-1:0]  cnt_inc;
  logic             accept;
  logic             fifo_ready;
  logic             push;
  logic [DW-1:0]    push_data;
  logic [DW-1:0]    head;

  // Inside a burst the latched operator applies to both the beat and the fold;
  // StAccum itself records that accMode was latched as 1.
  always_comb begin
    beat_op  = (state_q == StAccum) ? op_q : opSel;
    beat_res = WIDTH'(apply_op(beat_op, 32'(aIn), 32'(bIn)));
    fold_res = WIDTH'(apply_op(op_q, 32'(acc_q), 32'(beat_res)));
    cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
  end

  // Held low during reset; otherwise purely the queue occupancy register.
  assign inReady = rst_n && fifo_ready;
  assign accept  = inValid && inReady;

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (accept) begin
      if (state_q == StAccum) begin
        if (inLast) begin
          push      = 1'b1;
          push_data = {fold_res, op_q, cnt_inc};
        end
      end else if (!accMode || inLast) begin
        push      = 1'b1;
        push_data = {beat_res, opSel, CntOne};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (accMode && !inLast) begin
            state_q <= StAccum;
            acc_q   <= beat_res;
            op_q    <= opSel;
            cnt_q   <= CntOne;
          end
        end
        StAccum: begin
          if (inLast) begin
            state_q <= StIdle;
          end else begin
            acc_q <= fold_res;
            cnt_q <= cnt_inc;
          end
        end
      endcase
    end
  end

  logic_op_fifo2 #(
    .DW(DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (outReady),
    .ready     (fifo_ready),
    .valid     (outValid),
    .head      (head)
  );

  assign {out, opOut, beatCnt} = head;

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: directed scenarios plus a randomized run of logic_op_pipe
// (WIDTH=4, CNTW=2), checked against a burst-list reference model.
module tb_logic_op_pipe;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNTW  = 2;
  localparam int          CntCap = 3;

  typedef struct packed {
    logic [3:0] res;
    logic [1:0] op;
    logic [1:0] cnt;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [3:0] aIn = '0;
  logic [3:0] bIn = '0;
  logic [1:0] opSel = '0;
  logic       accMode = 1'b0;
  logic       inLast = 1'b0;
  logic       outValid;
  logic       outReady = 1'b0;
  logic [3:0] out;
  logic [1:0] opOut;
  logic [1:0] beatCnt;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  bit   rand_rdy = 1'b0;

  res_t       exp_q[$];
  res_t       got_q[$];
  bit         in_burst = 1'b0;
  logic [1:0] b_op = '0;
  logic [3:0] b_beats[$];

  logic_op_pipe #(
    .WIDTH(WIDTH),
    .CNTW (CNTW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .aIn      (aIn),
    .bIn      (bIn),
    .opSel    (opSel),
    .accMode  (accMode),
    .inLast   (inLast),
    .outValid (outValid),
    .outReady (outReady),
    .out      (out),
    .opOut    (opOut),
    .beatCnt  (beatCnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] lop(input logic [1:0] op, input logic [3:0] a,
                                     input logic [3:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Reference: collect a burst's beat results, left-fold them once it ends.
  task automatic model_beat(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                            input logic am, input logic last);
    logic [3:0] acc;
    int         n;
    if (!in_burst) begin
      if (am && !last) begin
        in_burst = 1'b1;
        b_op     = op;
        b_beats.delete();
        b_beats.push_back(lop(op, a, b));
      end else begin
        exp_q.push_back('{res: lop(op, a, b), op: op, cnt: 2'd1});
      end
    end else begin
      b_beats.push_back(lop(b_op, a, b));
      if (last) begin
        acc = b_beats[0];
        for (int i = 1; i < b_beats.size(); i++) acc = lop(b_op, acc, b_beats[i]);
        n = (b_beats.size() > CntCap) ? CntCap : b_beats.size();
        exp_q.push_back('{res: acc, op: b_op, cnt: 2'(n)});
        in_burst = 1'b0;
      end
    end
  endtask

  // Values seen at the falling edge are exactly what the next rising edge acts on.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("in_ready", 32'(inReady), 32'(exp_q.size() < 2));
      check_eq("out_valid", 32'(outValid), 32'(exp_q.size() != 0));
      if (outValid && exp_q.size() != 0) begin
        check_eq("out", 32'(out), 32'(exp_q[0].res));
        check_eq("op_out", 32'(opOut), 32'(exp_q[0].op));
        check_eq("beat_cnt", 32'(beatCnt), 32'(exp_q[0].cnt));
        if (outReady) begin
          got_q.push_back('{res: out, op: opOut, cnt: beatCnt});
          void'(exp_q.pop_front());
        end
      end
      if (inValid && inReady) model_beat(aIn, bIn, opSel, accMode, inLast);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) outReady = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
             n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input logic am, input logic last);
    int n = 0;
    aIn = a; bIn = b; opSel = op; accMode = am; inLast = last; inValid = 1'b1;
    @(negedge clk);
    while (!inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) check_eq("send_timeout", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    inValid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    outReady = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_idle"}, 32'(outValid), 32'd0);
  endtask

  task automatic check_got(input string tag, input int idx, input logic [3:0] r,
                           input logic [1:0] op, input logic [1:0] cnt);
    if (idx >= got_q.size()) begin
      check_eq({tag, "_missing"}, 32'(got_q.size()), 32'(idx + 1));
    end else begin
      check_eq({tag, "_res"}, 32'(got_q[idx].res), 32'(r));
      check_eq({tag, "_op"}, 32'(got_q[idx].op), 32'(op));
      check_eq({tag, "_cnt"}, 32'(got_q[idx].cnt), 32'(cnt));
    end
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_out_valid", 32'(outValid), 32'd0);
    check_eq("rst_in_ready", 32'(inReady), 32'd0);
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_op_out", 32'(opOut), 32'd0);
    check_eq("rst_beat_cnt", 32'(beatCnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(inReady), 32'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single beats under each operator, back to back
    outReady = 1'b1;
    got_q.delete();
    for (int op = 0; op < 4; op++) send(4'b1100, 4'b1010, 2'(op), 1'b0, 1'b0);
    idle(1);
    drain("ops_drain");
    check_got("op_and", 0, 4'b1000, 2'd0, 2'd1);
    check_got("op_or", 1, 4'b1110, 2'd1, 2'd1);
    check_got("op_xor", 2, 4'b0110, 2'd2, 2'd1);
    check_got("op_nor", 3, 4'b0001, 2'd3, 2'd1);

    // XOR burst of three
    got_q.delete();
    send(4'b0001, 4'b0000, 2'd2, 1'b1, 1'b0);
    send(4'b0010, 4'b0000, 2'd2, 1'b1, 1'b0);
    send(4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1);
    idle(1);
    drain("xor_drain");
    check_got("xor_burst", 0, 4'b0111, 2'd2, 2'd3);

    // Back-pressure: two fill the queue, the third is refused until drain
    got_q.delete();
    outReady = 1'b0;
    send(4'b0101, 4'b0011, 2'd0, 1'b0, 1'b0);
    send(4'b0101, 4'b0011, 2'd1, 1'b0, 1'b0);
    aIn = 4'b1111; bIn = 4'b0000; opSel = 2'd2; accMode = 1'b0; inLast = 1'b0;
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("full_ready", 32'(inReady), 32'd0);
      check_eq("stall_out", 32'(out), 32'(4'b0001));
      check_eq("stall_op", 32'(opOut), 32'd0);
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    send(4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0);
    idle(1);
    drain("bp_drain");
    check_got("bp_0", 0, 4'b0001, 2'd0, 2'd1);
    check_got("bp_1", 1, 4'b0111, 2'd1, 2'd1);
    check_got("bp_2", 2, 4'b1111, 2'd2, 2'd1);

    // Saturating count: five-beat AND burst with a 2-bit counter
    got_q.delete();
    for (int i = 0; i < 5; i++) send(4'b1111, 4'b1111, 2'd0, 1'b1, (i == 4));
    idle(1);
    drain("sat_drain");
    check_got("sat_burst", 0, 4'b1111, 2'd0, 2'd3);

    // Operator change mid-burst is ignored
    got_q.delete();
    send(4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0);
    send(4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);
    send(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b1);
    idle(1);
    drain("opchg_drain");
    check_got("opchg_burst", 0, 4'b1111, 2'd1, 2'd3);

    // Reset mid-burst with a result still queued
    outReady = 1'b0;
    send(4'b1010, 4'b0110, 2'd2, 1'b0, 1'b0);
    send(4'b0011, 4'b0001, 2'd1, 1'b1, 1'b0);
    send(4'b0100, 4'b0001, 2'd1, 1'b1, 1'b0);
    idle(1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(outValid), 32'd0);
    check_eq("mid_rst_ready", 32'(inReady), 32'd0);
    check_eq("mid_rst_out", 32'(out), 32'd0);
    check_eq("mid_rst_cnt", 32'(beatCnt), 32'd0);
    exp_q.delete();
    b_beats.delete();
    in_burst = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("mid_rst_rel_ready", 32'(inReady), 32'd1);
    mon_en = 1'b1;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    send(4'b0011, 4'b0101, 2'd1, 1'b0, 1'b0);
    idle(1);
    drain("post_rst_drain");
    check_got("post_rst_beat", 0, 4'b0111, 2'd1, 2'd1);
    check_eq("post_rst_count", 32'(got_q.size()), 32'd1);

    // Randomized traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        send(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      end
    end
    if (in_burst) send(4'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b1);
    rand_rdy = 1'b0;
    idle(1);
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
